controle_vedacao: RTL
=====================

# controle_vedacao

Sequencing controller for the bottling cell's conveyor, fill valve and corking press. It sits directly upstream of the cork-stock block. It consumes that block's on-line cork count to decide whether a bottle can be sealed. For every bottle sealed it emits a single-cycle `done` pulse, which the stock block uses to decrement its line count.

## Interface
- `T_VEDACAO`, default 4: cycles the corking press is held active per bottle (1..255).
- `T_ENCHE_MAX`, default 200: maximum fill cycles before a fill timeout (1..65535).
- `clk` input 1: single system clock, rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: level; enables the cell while high.
- `sensor_garrafa` input 1: bottle present at the fill/cork position.
- `sensor_nivel` input 1: fill level reached.
- `rolhas_linha` input 8: corks available on the line (from the stock block).
- `ack_erro` input 1: clears the error state.
- `motor_esteira` output 1: conveyor motor on.
- `valvula_enchimento` output 1: fill valve open.
- `acionar_vedacao` output 1: corking press active.
- `done` output 1: one-cycle pulse per sealed bottle.
- `alarme_sem_rolha` output 1: waiting in the seal state with no corks on the line.
- `erro_enchimento` output 1: fill timeout latched.
- `contagem_garrafas` output 8: total bottles sealed; wraps 255→0.
- `estado` output 3: current FSM state code, for debug and display.

## Operation
- All outputs are registered. Reset value of every output is 0; state is IDLE; internal timers are 0.
- States and codes:
  - IDLE=0, ESTEIRA=1, ENCHER=2, VEDAR=3, PRENSA=4, LIBERA=5, ERRO=6.
- IDLE: all actuators off.
  - `start`=1 → ESTEIRA.
- ESTEIRA: `motor_esteira`=1.
  - `sensor_garrafa`=1 → ENCHER, motor off.
- ENCHER: `valvula_enchimento`=1 and the fill timer counts up.
  - `sensor_nivel`=1 → VEDAR, valve closed, timer cleared.
  - Timer reaching `T_ENCHE_MAX` first → ERRO, `erro_enchimento`=1.
- VEDAR:
  - `rolhas_linha`==0 → stay in VEDAR with `alarme_sem_rolha`=1.
  - `rolhas_linha`>0 → PRENSA, alarm cleared.
- PRENSA: `acionar_vedacao`=1 for exactly `T_VEDACAO` cycles, then → LIBERA.
  - On the PRENSA→LIBERA transition: `done`=1 for one cycle and `contagem_garrafas` increments by 1.
- LIBERA: `motor_esteira`=1 until `sensor_garrafa`=0.
  - Then → ESTEIRA if `start`=1, else → IDLE.
- ERRO: all actuators off, `erro_enchimento`=1.
  - `ack_erro`=1 → IDLE and the flag clears.
- `start` falling:
  - In IDLE, ESTEIRA or VEDAR: → IDLE next cycle.
  - In ENCHER, PRENSA or LIBERA: the current step completes first. A bottle is never left half-filled or half-corked.
- Simultaneous `sensor_nivel` and timeout in the same cycle: level wins.
- Reset mid-operation: all outputs including `contagem_garrafas` return to 0 on the next edge; no `done` pulse is emitted.

## Timing
- Every input is sampled on the rising edge of `clk`. Each response appears on the next edge: 1-cycle latency from an input condition to the output change.
- `done` is never high on two consecutive cycles; at most one pulse per bottle.
- Bottle cycle with ideal sensors is 1 (ESTEIRA) + fill + 1 (VEDAR) + `T_VEDACAO` + LIBERA cycles.
- `rolhas_linha` is sampled only in VEDAR. A refill arriving while in VEDAR takes effect on the next edge.

## Configuration
- `CONTROLE_VEDACAO_DUZIA_EN` defined:
  - Adds output `caixa_completa` (1-bit), a one-cycle pulse coincident with every 12th `done` since reset.
  - Adds an internal 4-bit modulo-12 counter, cleared by `reset`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset and single bottle:
  - Stimulus: reset, `start`=1, `sensor_garrafa` high at cycle 3, `sensor_nivel` high at cycle 10, `rolhas_linha`=15.
  - Required: `acionar_vedacao` high exactly 4 cycles, one `done` pulse, `contagem_garrafas`=1.
- Empty line:
  - Stimulus: `rolhas_linha`=0 on entering VEDAR; raise it to 5 after 20 cycles.
  - Required: `alarme_sem_rolha`=1 for those 20 cycles, `acionar_vedacao`=0, then sealing proceeds and `done` pulses once.
- Fill timeout:
  - Stimulus: `T_ENCHE_MAX`=8, `sensor_nivel` held at 0.
  - Required: ERRO entered at fill cycle 8 with valve off and `erro_enchimento`=1. `ack_erro` returns to IDLE with the flag at 0.
- Stop mid-press:
  - Stimulus: drop `start` during PRENSA.
  - Required: press completes all `T_VEDACAO` cycles, `done` pulses, bottle is released, then IDLE.
- Counter wrap and macro:
  - Stimulus: 256 bottles sealed.
  - Required: `contagem_garrafas` returns to 0. With `CONTROLE_VEDACAO_DUZIA_EN` defined, `caixa_completa` pulses exactly 21 times.
- Reset mid-operation:
  - Stimulus: reset asserted during ENCHER.
  - Required: valve off, `estado`=0 and `contagem_garrafas`=0 on the next edge.

Source files
------------

// File: rtl/controle_vedacao.sv
// controle_vedacao: sequencing controller for conveyor, fill valve and corking press.
// Optional build macro CONTROLE_VEDACAO_DUZIA_EN adds the caixa_completa output, which
// pulses with every 12th done.
module controle_vedacao #(
  parameter int unsigned T_VEDACAO   = 4,
  parameter int unsigned T_ENCHE_MAX = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sensor_garrafa,
  input  logic       sensor_nivel,
  input  logic [7:0] rolhas_linha,
  input  logic       ack_erro,
  output logic       motor_esteira,
  output logic       valvula_enchimento,
  output logic       acionar_vedacao,
  output logic       done,
  output logic       alarme_sem_rolha,
  output logic       erro_enchimento,
  output logic [7:0] contagem_garrafas,
`ifdef CONTROLE_VEDACAO_DUZIA_EN
  output logic       caixa_completa,
`endif
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEsteira = 3'd1,
    StEncher  = 3'd2,
    StVedar   = 3'd3,
    StPrensa  = 3'd4,
    StLibera  = 3'd5,
    StErro    = 3'd6
  } state_e;

  localparam logic [16:0] TEncheMax = 17'(T_ENCHE_MAX);
  localparam logic [16:0] TVedacao  = 17'(T_VEDACAO);

  state_e      state_q, state_d;
  // Shared step timer: counts fill cycles in ENCHER and press cycles in PRENSA.
  logic [15:0] timer_q, timer_d;
  logic [16:0] timer_inc;

  logic       motor_d, valvula_d, acionar_d, done_d, alarme_d, erro_d;
  logic [7:0] contagem_d;

  assign timer_inc = {1'b0, timer_q} + 17'd1;
  assign estado    = state_q;

  // State register and step timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; ENCHER and PRENSA ignore start so a bottle is never left mid-step.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StEsteira;
      end
      StEsteira: begin
        if (!start)              state_d = StIdle;
        else if (sensor_garrafa) state_d = StEncher;
      end
      StEncher: begin
        // Level has priority over a timeout landing on the same edge.
        if (sensor_nivel)                state_d = StVedar;
        else if (timer_inc >= TEncheMax) state_d = StErro;
        else                             timer_d = timer_inc[15:0];
      end
      StVedar: begin
        if (!start)                   state_d = StIdle;
        else if (rolhas_linha != '0)  state_d = StPrensa;
      end
      StPrensa: begin
        if (timer_inc >= TVedacao) state_d = StLibera;
        else                       timer_d = timer_inc[15:0];
      end
      StLibera: begin
        if (!sensor_garrafa) state_d = start ? StEsteira : StIdle;
      end
      StErro: begin
        if (ack_erro) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next values, derived from the state being entered so outputs track estado.
  always_comb begin
    motor_d    = (state_d == StEsteira) || (state_d == StLibera);
    valvula_d  = (state_d == StEncher);
    acionar_d  = (state_d == StPrensa);
    done_d     = (state_q == StPrensa) && (state_d == StLibera);
    alarme_d   = (state_q == StVedar) && (state_d == StVedar) && (rolhas_linha == '0);
    erro_d     = (state_d == StErro);
    contagem_d = contagem_garrafas + {7'd0, done_d};
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_esteira      <= 1'b0;
      valvula_enchimento <= 1'b0;
      acionar_vedacao    <= 1'b0;
      done               <= 1'b0;
      alarme_sem_rolha   <= 1'b0;
      erro_enchimento    <= 1'b0;
      contagem_garrafas  <= '0;
    end else begin
      motor_esteira      <= motor_d;
      valvula_enchimento <= valvula_d;
      acionar_vedacao    <= acionar_d;
      done               <= done_d;
      alarme_sem_rolha   <= alarme_d;
      erro_enchimento    <= erro_d;
      contagem_garrafas  <= contagem_d;
    end
  end

`ifdef CONTROLE_VEDACAO_DUZIA_EN
  logic [3:0] duzia_q;

  // Modulo-12 count of sealed bottles; caixa_completa fires alongside the 12th done.
  always_ff @(posedge clk) begin
    if (reset) begin
      duzia_q        <= '0;
      caixa_completa <= 1'b0;
    end else begin
      caixa_completa <= done_d && (duzia_q == 4'd11);
      if (done_d) duzia_q <= (duzia_q == 4'd11) ? 4'd0 : duzia_q + 4'd1;
    end
  end
`endif

endmodule
